data_memory_responder: RTL and testbench
========================================

// Module: data_memory_responder
// PURPOSE
// - Responder end of the CPU data-memory interface. Services the CPU's address/size/read/write
//   requests against a byte-addressed, little-endian RAM of 2**ADDR_W bytes.
// - Writes commit at the accept edge. Reads return data after a programmable latency.
// - Flags malformed requests on a sticky error vector; it sits beside the CPU in the top level.
// PARAMETERS
// - ADDR_W        12  RAM size is 2**ADDR_W bytes, stored as 2**(ADDR_W-2) 32-bit words
// - READ_LATENCY  1   clk_en-qualified cycles from read accept to mem_valid; legal range 1..4
// PORTS
// - clk        in   1   core clock; all state updates on posedge
// - nreset     in   1   asynchronous, active-low reset
// - clk_en     in   1   clock enable; when low, all state (FSM, counter, RAM, errors) holds
// - mem_a      in   32  byte address
// - mem_wdata  in   32  write value; the lane is selected by mem_s and mem_a[1:0]
// - mem_s      in   2   access size: 00 byte, 01 halfword, 10 word, 11 illegal
// - mem_read   in   1   read request, level-sampled at the edge
// - mem_write  in   1   write request, level-sampled at the edge
// - mem_rdata  out  32  read value, zero-extended, right-justified
// - mem_valid  out  1   one-cycle pulse while mem_rdata holds a completed read
// - mem_busy   out  1   high while a read is outstanding
// - mem_err    out  4   sticky error flags: [0] misaligned, [1] out of range, [2] read&write together,
//                       [3] illegal size, or request while busy
// BEHAVIOUR
// - Reset, asynchronous on nreset low:
//   - State goes to IDLE.
//   - mem_rdata=0, mem_valid=0, mem_busy=0, mem_err=0, latency counter=0.
//   - RAM contents are retained, and are not defined after power-up.
//   - Reset asserted mid-read aborts the read; no mem_valid is produced.
// - Accept: a request is accepted at a posedge with clk_en=1, state IDLE, (mem_read|mem_write)=1,
//   and no error condition present.
// - Error checks, evaluated on every sampled request. Any hit means the access is not performed,
//   the bit is ORed into mem_err, and the FSM stays in its current state.
//   - [0] misaligned: s=01 with a[0]!=0, or s=10 with a[1:0]!=0.
//   - [1] out of range: a[31:ADDR_W] != 0.
//   - [2] mem_read and mem_write both high.
//   - [3] s=11, or any request while BUSY. The in-flight read continues unaffected.
//   - Several bits may set in one cycle. mem_err clears only on reset.
// - Write:
//   - Byte: RAM byte a <= wdata[7:0].
//   - Half: bytes a, a+1 <= wdata[7:0], wdata[15:8].
//   - Word: bytes a..a+3 <= wdata[31:0], little-endian.
//   - Other bytes of the word are unchanged. Write latency 0; no mem_valid pulse for writes.
// - Read:
//   - At accept, latch the word at a[ADDR_W-1:2], plus a[1:0] and s; load the counter with
//     READ_LATENCY-1.
//   - If READ_LATENCY=1: next state is IDLE; mem_valid=1 for the following cycle.
//   - Otherwise: go to BUSY.
// - FSM IDLE -> BUSY: on read accept with READ_LATENCY>1; mem_busy=1 in BUSY.
// - FSM BUSY: on each clk_en edge, counter decrements.
//   - When the counter is 1 at an edge, next state is IDLE and mem_valid=1 for exactly one
//     clk_en cycle.
//   - This gives exactly READ_LATENCY clk_en edges from accept to the valid cycle.
// - A new request may be accepted in the same cycle mem_valid is high, since state is IDLE.
// - mem_rdata: byte/half/word extracted from the latched word per a[1:0], upper bits zero.
//   - Updated only when mem_valid asserts; holds its value otherwise.
// - Read-after-write: a read accepted in the cycle after a write returns the new data.
//   RAM writes are never deferred.
// - clk_en low: mem_valid, mem_busy, mem_rdata and mem_err hold. A pending mem_valid stays
//   asserted until the next clk_en edge.
// TESTING
// - Reset, then read word 0x00000010 with READ_LATENCY=1 -> mem_valid pulses the cycle after
//   accept; mem_err=0.
// - Write word 0xDEADBEEF to 0x20, then read byte 0x21 and half 0x22 -> mem_rdata=0x000000BE,
//   then 0x0000DEAD.
// - Write byte 0x5A to 0x23 after word 0x11223344 at 0x20, then read word 0x20 ->
//   mem_rdata=0x5A223344.
// - Read half at 0x31 -> mem_err=4'b0001, no mem_valid, RAM unchanged.
//   Then read at 0x00001000 with ADDR_W=12 -> mem_err=4'b0011.
// - READ_LATENCY=3: read 0x40, issue a write 1 cycle later, drop clk_en for 2 cycles mid-read
//   -> write dropped, mem_err[3]=1, mem_valid exactly 3 clk_en edges after accept.
// - Reset asserted while BUSY -> mem_busy=0, mem_valid never pulses; mem_err=0 afterwards.

Source files
------------

// File: rtl/data_memory_responder.sv
// data_memory_responder
//   Responder end of the CPU data-memory interface. Services byte, halfword
//   and word requests against a little-endian RAM of 2**ADDR_W bytes, held
//   as 2**(ADDR_W-2) 32-bit words. Writes commit at the accept edge; reads
//   return after READ_LATENCY clk_en-qualified edges (legal range 1..4).
//   Malformed requests are dropped and recorded on a sticky error vector.
//
// Ports
//   clk        in   core clock, all state updates on posedge
//   nreset     in   asynchronous active-low reset (RAM contents retained)
//   clk_en     in   clock enable; all state holds while low
//   mem_a      in   [31:0] byte address
//   mem_wdata  in   [31:0] write value, lane chosen by mem_s / mem_a[1:0]
//   mem_s      in   [1:0]  size: 00 byte, 01 half, 10 word, 11 illegal
//   mem_read   in   read request (level-sampled)
//   mem_write  in   write request (level-sampled)
//   mem_rdata  out  [31:0] zero-extended, right-justified read value
//   mem_valid  out  one clk_en-cycle pulse when mem_rdata holds a new read
//   mem_busy   out  high while a read is outstanding
//   mem_err    out  [3:0] sticky: misaligned, out of range, read&write,
//                   illegal size or request while busy
module data_memory_responder #(
  parameter int ADDR_W       = 12,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        clk_en,
  input  logic [31:0] mem_a,
  input  logic [31:0] mem_wdata,
  input  logic [1:0]  mem_s,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] mem_rdata,
  output logic        mem_valid,
  output logic        mem_busy,
  output logic [3:0]  mem_err
);

  localparam int WORDS = 2 ** (ADDR_W - 2);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nxt;
  logic [2:0]        cnt_p1, cnt_nxt;
  logic              vld_nxt;
  logic [31:0]       rdata_nxt;

  logic [31:0]       ram [WORDS];
  logic [ADDR_W-3:0] widx;
  logic              req;
  logic [3:0]        err_hit;
  logic              accept, rd_acc, wr_acc;
  logic [3:0]        be;
  logic [31:0]       wlane;

  logic [31:0]       rd_word_p1;
  logic [1:0]        rd_off_p1;
  logic [1:0]        rd_size_p1;

  // Right-justify the addressed lane of a word and zero the upper bits.
  function automatic logic [31:0] extract(input logic [31:0] w,
                                          input logic [1:0]  off,
                                          input logic [1:0]  sz);
    logic [31:0] sh;
    sh = w >> {off, 3'b000};
    case (sz)
      2'b00:   return {24'b0, sh[7:0]};
      2'b01:   return {16'b0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  assign widx     = mem_a[ADDR_W-1:2];
  assign req      = mem_read | mem_write;
  assign mem_busy = (state == BUSY);

  // Request decode: error classification, accept and write lanes.
  always_comb begin
    err_hit[0] = ((mem_s == 2'b01) && mem_a[0]) ||
                 ((mem_s == 2'b10) && (mem_a[1:0] != 2'b00));
    err_hit[1] = |mem_a[31:ADDR_W];
    err_hit[2] = mem_read & mem_write;
    err_hit[3] = (mem_s == 2'b11) || (state == BUSY);
    accept     = req && (state == IDLE) && (err_hit == 4'b0000);
    rd_acc     = accept & mem_read;
    wr_acc     = accept & mem_write;

    case (mem_s)
      2'b00: begin
        be    = 4'b0001 << mem_a[1:0];
        wlane = {4{mem_wdata[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << {mem_a[1], 1'b0};
        wlane = {2{mem_wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = mem_wdata;
      end
    endcase
  end

  // FSM next state, countdown and read-data selection.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_p1;
    vld_nxt   = 1'b0;
    rdata_nxt = extract(rd_word_p1, rd_off_p1, rd_size_p1);
    case (state)
      IDLE: begin
        if (rd_acc) begin
          cnt_nxt = 3'(READ_LATENCY - 1);
          if (READ_LATENCY == 1) begin
            // Single-cycle read completes straight from the RAM word.
            vld_nxt   = 1'b1;
            rdata_nxt = extract(ram[widx], mem_a[1:0], mem_s);
          end else begin
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_nxt = cnt_p1 - 3'd1;
        if (cnt_p1 == 3'd1) begin
          state_nxt = IDLE;
          vld_nxt   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: control state, response and sticky errors.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= IDLE;
      cnt_p1    <= 3'd0;
      mem_valid <= 1'b0;
      mem_rdata <= 32'd0;
      mem_err   <= 4'd0;
    end else if (clk_en) begin
      state     <= state_nxt;
      cnt_p1    <= cnt_nxt;
      mem_valid <= vld_nxt;
      if (vld_nxt)
        mem_rdata <= rdata_nxt;
      if (req)
        mem_err <= mem_err | err_hit;
    end
  end

  // Stage p1: read capture at accept (data path, not reset).
  always_ff @(posedge clk) begin
    if (clk_en && rd_acc) begin
      rd_word_p1 <= ram[widx];
      rd_off_p1  <= mem_a[1:0];
      rd_size_p1 <= mem_s;
    end
  end

  // RAM byte-lane write; commits at the accept edge, never deferred.
  always_ff @(posedge clk) begin
    if (clk_en && wr_acc) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b])
          ram[widx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: two instances (READ_LATENCY 1 and 3)
// share one stimulus stream; a byte-level reference model predicts every
// output after every edge.
module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        nreset, clk_en;
  logic [31:0] a, wd;
  logic [1:0]  s;
  logic        rd, wr;
  logic [31:0] rdata0, rdata1;
  logic        v0, v1, b0, b1;
  logic [3:0]  e0, e1;

  always #5 clk = ~clk;

  data_memory_responder #(.ADDR_W(12), .READ_LATENCY(1)) dut0 (
    .clk(clk), .nreset(nreset), .clk_en(clk_en), .mem_a(a), .mem_wdata(wd),
    .mem_s(s), .mem_read(rd), .mem_write(wr), .mem_rdata(rdata0),
    .mem_valid(v0), .mem_busy(b0), .mem_err(e0));

  data_memory_responder #(.ADDR_W(12), .READ_LATENCY(3)) dut1 (
    .clk(clk), .nreset(nreset), .clk_en(clk_en), .mem_a(a), .mem_wdata(wd),
    .mem_s(s), .mem_read(rd), .mem_write(wr), .mem_rdata(rdata1),
    .mem_valid(v1), .mem_busy(b1), .mem_err(e1));

  int n_chk  = 0;
  int n_pass = 0;
  int cnum   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference model: byte memory and "edges remaining until data" per instance.
  logic [7:0]  mb [2][4096];
  int          rem [2];
  logic [31:0] pend [2];
  logic [31:0] m_rdata [2];
  logic        m_valid [2];
  logic [3:0]  m_err [2];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      rem[k] = 0; m_valid[k] = 1'b0; m_rdata[k] = 32'd0; m_err[k] = 4'd0;
    end
  endtask

  function automatic logic [31:0] model_read(input int k, input logic [31:0] addr, input logic [1:0] sz);
    int i;
    i = int'(addr[11:0]);
    case (sz)
      2'b00:   return {24'b0, mb[k][i]};
      2'b01:   return {16'b0, mb[k][i+1], mb[k][i]};
      default: return {mb[k][i+3], mb[k][i+2], mb[k][i+1], mb[k][i]};
    endcase
  endfunction

  task automatic model_edge();
    logic mis, oor, both, ill, busy, req;
    logic [31:0] data;
    int i, n;
    if (!clk_en) return;
    req  = rd | wr;
    mis  = (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
    oor  = (a[31:12] != 20'd0);
    both = rd & wr;
    ill  = (s == 2'b11);
    for (int k = 0; k < 2; k++) begin
      busy = (rem[k] > 0);
      m_valid[k] = 1'b0;
      if (req) m_err[k] = m_err[k] | {ill | busy, both, oor, mis};
      if (busy) begin
        rem[k]--;
        if (rem[k] == 0) begin
          m_valid[k] = 1'b1;
          m_rdata[k] = pend[k];
        end
      end else if (req && !(mis || oor || both || ill)) begin
        i = int'(a[11:0]);
        if (wr) begin
          n = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
          for (int j = 0; j < n; j++) mb[k][i+j] = wd[8*j +: 8];
        end else begin
          data = model_read(k, a, s);
          if (lat_of(k) == 1) begin
            m_valid[k] = 1'b1;
            m_rdata[k] = data;
          end else begin
            rem[k]  = lat_of(k) - 1;
            pend[k] = data;
          end
        end
      end
    end
  endtask

  task automatic compare(input string where);
    check_eq($sformatf("%s valid0", where), {31'b0, v0}, {31'b0, m_valid[0]});
    check_eq($sformatf("%s busy0",  where), {31'b0, b0}, {31'b0, rem[0] > 0});
    check_eq($sformatf("%s rdata0", where), rdata0, m_rdata[0]);
    check_eq($sformatf("%s err0",   where), {28'b0, e0}, {28'b0, m_err[0]});
    check_eq($sformatf("%s valid1", where), {31'b0, v1}, {31'b0, m_valid[1]});
    check_eq($sformatf("%s busy1",  where), {31'b0, b1}, {31'b0, rem[1] > 0});
    check_eq($sformatf("%s rdata1", where), rdata1, m_rdata[1]);
    check_eq($sformatf("%s err1",   where), {28'b0, e1}, {28'b0, m_err[1]});
  endtask

  // Called at a negedge; drives one cycle and checks after the edge.
  task automatic cyc(input logic en, input logic [31:0] addr, input logic [31:0] data,
                     input logic [1:0] sz, input logic r, input logic w);
    clk_en = en; a = addr; wd = data; s = sz; rd = r; wr = w;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cnum++;
    compare($sformatf("c%0d", cnum));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted between edges; called at a negedge.
  task automatic do_reset();
    rd = 1'b0; wr = 1'b0;
    #2 nreset = 1'b0;
    #1 model_reset();
    compare("rst");
    @(negedge clk);
    nreset = 1'b1;
  endtask

  initial begin
    logic [31:0] addr;
    logic [1:0]  sz;
    int          op;
    nreset = 1'b0; clk_en = 1'b0; a = 0; wd = 0; s = 0; rd = 0; wr = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Give every RAM word a known value.
    for (int i = 0; i < 1024; i++) cyc(1'b1, 32'(i * 4), $urandom(), 2'b10, 1'b0, 1'b1);
    do_reset();

    cyc(1'b1, 32'h10, 32'd0, 2'b10, 1'b1, 1'b0);
    check_eq("rl1 valid after accept", {31'b0, v0}, 32'd1);
    check_eq("rl1 err clean", {28'b0, e0}, 32'd0);
    idle(3);

    cyc(1'b1, 32'h20, 32'hDEADBEEF, 2'b10, 1'b0, 1'b1);
    cyc(1'b1, 32'h21, 32'd0, 2'b00, 1'b1, 1'b0);
    idle(3);
    check_eq("byte 0x21 lat1", rdata0, 32'h000000BE);
    check_eq("byte 0x21 lat3", rdata1, 32'h000000BE);
    cyc(1'b1, 32'h22, 32'd0, 2'b01, 1'b1, 1'b0);
    idle(3);
    check_eq("half 0x22 lat1", rdata0, 32'h0000DEAD);
    check_eq("half 0x22 lat3", rdata1, 32'h0000DEAD);

    cyc(1'b1, 32'h20, 32'h11223344, 2'b10, 1'b0, 1'b1);
    cyc(1'b1, 32'h23, 32'h0000005A, 2'b00, 1'b0, 1'b1);
    cyc(1'b1, 32'h20, 32'd0, 2'b10, 1'b1, 1'b0);
    idle(3);
    check_eq("merged word lat1", rdata0, 32'h5A223344);
    check_eq("merged word lat3", rdata1, 32'h5A223344);

    cyc(1'b1, 32'h31, 32'd0, 2'b01, 1'b1, 1'b0);
    check_eq("misaligned err", {28'b0, e0}, 32'h1);
    check_eq("misaligned no valid", {31'b0, v0}, 32'd0);
    cyc(1'b1, 32'h1000, 32'd0, 2'b10, 1'b1, 1'b0);
    check_eq("range err lat1", {28'b0, e0}, 32'h3);
    check_eq("range err lat3", {28'b0, e1}, 32'h3);
    do_reset();

    // Latency 3 with a write while busy and clk_en dropped mid-read.
    cyc(1'b1, 32'h40, 32'd0, 2'b10, 1'b1, 1'b0);
    cyc(1'b1, 32'h80, 32'hCAFEF00D, 2'b10, 1'b0, 1'b1);
    cyc(1'b0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0);
    check_eq("rl3 not yet valid", {31'b0, v1}, 32'd0);
    idle(1);
    check_eq("rl3 valid on 3rd edge", {31'b0, v1}, 32'd1);
    check_eq("rl3 busy-request err", {31'b0, e1[3]}, 32'd1);
    cyc(1'b1, 32'h80, 32'd0, 2'b10, 1'b1, 1'b0);
    idle(3);
    do_reset();

    // Reset while a latency-3 read is outstanding.
    cyc(1'b1, 32'h40, 32'd0, 2'b10, 1'b1, 1'b0);
    check_eq("busy before reset", {31'b0, b1}, 32'd1);
    do_reset();
    idle(5);
    check_eq("err after abort", {28'b0, e1}, 32'd0);

    // Randomized traffic.
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      sz   = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      addr = 32'($urandom_range(0, 4095));
      if ($urandom_range(0, 7) != 0) begin
        if (sz == 2'b01) addr[0] = 1'b0;
        if (sz == 2'b10) addr[1:0] = 2'b00;
      end
      if ($urandom_range(0, 19) == 0) addr[31:12] = 20'($urandom_range(1, 1048575));
      op = $urandom_range(0, 9);
      cyc($urandom_range(0, 4) != 0, addr, $urandom(), sz,
          (op <= 3) || (op == 7), (op >= 4 && op <= 7));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
